mc_ctrl_fsm: RTL and testbench

//  Multicycle control FSM for the RV32I core; sequences the PC, PC_old, IR, regfile, ALU and memory

---
 rtl/mc_ctrl_fsm_pkg.sv | 65 ++++++
 rtl/mc_ctrl_fsm_if.sv | 35 +++
 rtl/mc_ctrl_fsm.sv | 176 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: opcodes, state codes
// and datapath mux/ALU selects.
package mc_ctrl_fsm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EX_R     = 4'd2;
    localparam logic [3:0] S_EX_I     = 4'd3;
    localparam logic [3:0] S_EX_LUI   = 4'd4;
    localparam logic [3:0] S_EX_AUIPC = 4'd5;
    localparam logic [3:0] S_EX_B     = 4'd6;
    localparam logic [3:0] S_EX_JAL   = 4'd7;
    localparam logic [3:0] S_EX_JALR  = 4'd8;
    localparam logic [3:0] S_MEM_ADDR = 4'd9;
    localparam logic [3:0] S_MEM_RD   = 4'd10;
    localparam logic [3:0] S_MEM_WR   = 4'd11;
    localparam logic [3:0] S_WB_ALU   = 4'd12;
    localparam logic [3:0] S_WB_MEM   = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_RS1   = 2'd1;
    localparam logic [1:0] SRCA_PCOLD = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_FUNCT = 2'd1;
    localparam logic [1:0] ALUOP_PASSB = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    function automatic logic [3:0] decode_dispatch(input logic [6:0] op);
        case (op)
            OP_R:              return S_EX_R;
            OP_I:              return S_EX_I;
            OP_LOAD, OP_STORE: return S_MEM_ADDR;
            OP_BRANCH:         return S_EX_B;
            OP_JAL:            return S_EX_JAL;
            OP_JALR:           return S_EX_JALR;
            OP_LUI:            return S_EX_LUI;
            OP_AUIPC:          return S_EX_AUIPC;
            default:           return S_TRAP;
        endcase
    endfunction

    function automatic logic is_mem_wait(input logic [3:0] st);
        return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle FSM (master) and the RV32I datapath (slave).
interface mc_ctrl_fsm_if;
    import mc_ctrl_fsm_pkg::*;

    logic [6:0] opcode;
    logic       F3_result;
    logic       mem_ready;
    logic       PCWr;
    logic       PColdWr;
    logic       IRWr;
    logic       RegWr;
    logic       MemRd;
    logic       MemWr;
    logic       IorD;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       PCSrc;
    logic [1:0] WBSel;
    logic       trap;
    logic [3:0] state_o;

    modport master (
        input  opcode, F3_result, mem_ready,
        output PCWr, PColdWr, IRWr, RegWr, MemRd, MemWr, IorD,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, WBSel, trap, state_o
    );

    modport slave (
        output opcode, F3_result, mem_ready,
        input  PCWr, PColdWr, IRWr, RegWr, MemRd, MemWr, IorD,
               ALUSrcA, ALUSrcB, ALUOp, PCSrc, WBSel, trap, state_o
    );

endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM for the RV32I core: one instruction at a time, with a
// memory-wait timeout that parks the core in TRAP until reset.
//
// state      | meaning
// FETCH      | read instruction at PC; on mem_ready latch IR, PC_old, PC<=PC+4
// DECODE     | ALUOut <= PC_old+imm, dispatch on opcode
// EX_R/EX_I  | ALU op on rs1 with rs2/imm
// EX_LUI     | ALU passes imm
// EX_AUIPC   | ALU computes PC_old+imm
// EX_B       | PC <= ALUOut when the branch condition holds
// EX_JAL     | rd <= PC, PC <= ALUOut
// EX_JALR    | rd <= PC, PC <= rs1+imm
// MEM_ADDR   | ALU computes rs1+imm
// MEM_RD/WR  | data access at ALUOut, held until mem_ready
// WB_ALU/MEM | write ALUOut / MDR to rd
// TRAP       | illegal opcode or memory timeout, left only by reset
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RSTn,
    mc_ctrl_fsm_if.master bus
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [3:0] state_q, state_d;
    logic [7:0] wait_cnt_q;
    logic       mem_waiting;
    logic       timeout_hit;

    logic       pc_wr, pc_old_wr, ir_wr, reg_wr, mem_rd, mem_wr, iord, pc_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;

    assign mem_waiting = is_mem_wait(state_q) && !bus.mem_ready;
    // mem_ready on the limit cycle is not a waiting cycle, so it completes normally
    assign timeout_hit = mem_waiting && (wait_cnt_q == TO_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= mem_waiting ? wait_cnt_q + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready)    state_d = S_DECODE;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_DECODE:   state_d = decode_dispatch(bus.opcode);
            S_EX_R, S_EX_I, S_EX_LUI, S_EX_AUIPC:
                        state_d = S_WB_ALU;
            S_EX_B, S_EX_JAL, S_EX_JALR:
                        state_d = S_FETCH;
            S_MEM_ADDR: state_d = bus.opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (bus.mem_ready)    state_d = S_WB_MEM;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (bus.mem_ready)    state_d = S_FETCH;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_WB_ALU, S_WB_MEM:
                        state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
    end

    always_comb begin
        pc_wr     = 1'b0;
        pc_old_wr = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        iord      = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        wb_sel    = WB_ALUOUT;
        case (state_q)
            S_FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_wr     = 1'b1;
                    pc_old_wr = 1'b1;
                    pc_wr     = 1'b1;
                    alu_src_b = SRCB_FOUR;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_PCOLD;
                alu_src_b = SRCB_IMM;
            end
            S_EX_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EX_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_EX_LUI: begin
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_PASSB;
            end
            S_EX_AUIPC: begin
                alu_src_a = SRCA_PCOLD;
                alu_src_b = SRCB_IMM;
            end
            S_EX_B: begin
                pc_src = 1'b1;
                pc_wr  = bus.F3_result;
            end
            S_EX_JAL: begin
                reg_wr = 1'b1;
                wb_sel = WB_PC;
                pc_src = 1'b1;
                pc_wr  = 1'b1;
            end
            S_EX_JALR: begin
                reg_wr    = 1'b1;
                wb_sel    = WB_PC;
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                pc_wr     = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                iord   = 1'b1;
                mem_rd = 1'b1;
            end
            S_MEM_WR: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_WB_ALU: reg_wr = 1'b1;
            S_WB_MEM: begin
                reg_wr = 1'b1;
                wb_sel = WB_MDR;
            end
            default: ;
        endcase
    end

    assign bus.PCWr    = pc_wr;
    assign bus.PColdWr = pc_old_wr;
    assign bus.IRWr    = ir_wr;
    assign bus.RegWr   = reg_wr;
    assign bus.MemRd   = mem_rd;
    assign bus.MemWr   = mem_wr;
    assign bus.IorD    = iord;
    assign bus.ALUSrcA = alu_src_a;
    assign bus.ALUSrcB = alu_src_b;
    assign bus.ALUOp   = alu_op;
    assign bus.PCSrc   = pc_src;
    assign bus.WBSel   = wb_sel;
    assign bus.trap    = (state_q == S_TRAP);
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instruction walks plus random instruction
// streams compared each cycle against a per-instruction step-list model.
module tb_mc_ctrl_fsm;
    import mc_ctrl_fsm_pkg::*;

    localparam int TO = 4;

    typedef struct packed {
        logic       pcwr;
        logic       pcoldwr;
        logic       irwr;
        logic       regwr;
        logic       memrd;
        logic       memwr;
        logic       iord;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       pcsrc;
        logic [1:0] wb;
        logic       trap;
    } outs_t;

    logic CLK  = 1'b0;
    logic RSTn = 1'b1;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0] m_step;
    logic [3:0] m_plan[$];
    int         m_wait;
    logic [6:0] opc_cur;

    logic [3:0] obs_state;
    outs_t      obs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    function automatic outs_t sample();
        outs_t o;
        o = '{bus.PCWr, bus.PColdWr, bus.IRWr, bus.RegWr, bus.MemRd, bus.MemWr, bus.IorD,
              bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.WBSel, bus.trap};
        return o;
    endfunction

    // Expected control word for each step of an instruction, straight from the step table.
    function automatic outs_t exp_out(input logic [3:0] st, input logic rdy, input logic f3);
        outs_t o;
        o = '0;
        case (st)
            S_FETCH: begin
                o.memrd = 1;
                if (rdy) begin o.irwr = 1; o.pcoldwr = 1; o.pcwr = 1; o.b = SRCB_FOUR; end
            end
            S_DECODE:   begin o.a = SRCA_PCOLD; o.b = SRCB_IMM; end
            S_EX_R:     begin o.a = SRCA_RS1; o.op = ALUOP_FUNCT; end
            S_EX_I:     begin o.a = SRCA_RS1; o.b = SRCB_IMM; o.op = ALUOP_FUNCT; end
            S_EX_LUI:   begin o.b = SRCB_IMM; o.op = ALUOP_PASSB; end
            S_EX_AUIPC: begin o.a = SRCA_PCOLD; o.b = SRCB_IMM; end
            S_EX_B:     begin o.pcsrc = 1; o.pcwr = f3; end
            S_EX_JAL:   begin o.regwr = 1; o.wb = WB_PC; o.pcsrc = 1; o.pcwr = 1; end
            S_EX_JALR:  begin o.regwr = 1; o.wb = WB_PC; o.a = SRCA_RS1; o.b = SRCB_IMM; o.pcwr = 1; end
            S_MEM_ADDR: begin o.a = SRCA_RS1; o.b = SRCB_IMM; end
            S_MEM_RD:   begin o.iord = 1; o.memrd = 1; end
            S_MEM_WR:   begin o.iord = 1; o.memwr = 1; end
            S_WB_ALU:   o.regwr = 1;
            S_WB_MEM:   begin o.regwr = 1; o.wb = WB_MDR; end
            S_TRAP:     o.trap = 1;
            default:    o = '1;
        endcase
        return o;
    endfunction

    task automatic push_plan(input logic [6:0] op);
        case (op)
            OP_R:      begin m_plan.push_back(S_EX_R);     m_plan.push_back(S_WB_ALU); end
            OP_I:      begin m_plan.push_back(S_EX_I);     m_plan.push_back(S_WB_ALU); end
            OP_LUI:    begin m_plan.push_back(S_EX_LUI);   m_plan.push_back(S_WB_ALU); end
            OP_AUIPC:  begin m_plan.push_back(S_EX_AUIPC); m_plan.push_back(S_WB_ALU); end
            OP_LOAD:   begin m_plan.push_back(S_MEM_ADDR); m_plan.push_back(S_MEM_RD); m_plan.push_back(S_WB_MEM); end
            OP_STORE:  begin m_plan.push_back(S_MEM_ADDR); m_plan.push_back(S_MEM_WR); end
            OP_BRANCH: m_plan.push_back(S_EX_B);
            OP_JAL:    m_plan.push_back(S_EX_JAL);
            OP_JALR:   m_plan.push_back(S_EX_JALR);
            default:   m_plan.push_back(S_TRAP);
        endcase
    endtask

    task automatic model_reset();
        m_step = S_FETCH;
        m_plan.delete();
        m_wait = 0;
    endtask

    task automatic model_advance(input logic rdy);
        if (m_step == S_TRAP) return;
        if ((m_step == S_FETCH || m_step == S_MEM_RD || m_step == S_MEM_WR) && !rdy) begin
            m_wait++;
            if (m_wait == TO) begin
                m_step = S_TRAP;
                m_plan.delete();
            end
            return;
        end
        m_wait = 0;
        if (m_step == S_FETCH)       m_plan.push_back(S_DECODE);
        else if (m_step == S_DECODE) push_plan(opc_cur);
        m_step = (m_plan.size() == 0) ? S_FETCH : m_plan.pop_front();
    endtask

    // Called at posedge+1; compares at the following negedge, returns at next posedge+1.
    task automatic cyc(input logic rdy, input logic f3);
        bus.mem_ready = rdy;
        bus.F3_result = f3;
        bus.opcode    = opc_cur;
        #4;
        obs_state = bus.state_o;
        obs       = sample();
        chk("state", 32'(obs_state), 32'(m_step));
        chk("outputs", 32'(obs), 32'(exp_out(m_step, rdy, f3)));
        model_advance(rdy);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        #1;
        chk("rst_state", 32'(bus.state_o), 32'(S_FETCH));
        chk("rst_trap", 32'(bus.trap), 32'd0);
        chk("rst_memwr", 32'(bus.MemWr), 32'd0);
        chk("rst_memrd", 32'(bus.MemRd), 32'd1);
        model_reset();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    logic [6:0] legal_ops[9];
    logic [3:0] st_log[4];
    logic [3:0] wr_log[4];
    int         memrd_cycles;
    int         trap_cycles;

    initial begin
        legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        bus.mem_ready = 1'b1;
        bus.F3_result = 1'b0;
        bus.opcode    = 7'd0;
        opc_cur       = OP_R;
        model_reset();
        #1;
        do_reset();

        // R-type: four-cycle walk, fetch strobes in cycle 0, RegWr in cycle 3 only
        opc_cur = OP_R;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            st_log[i] = obs_state;
            wr_log[i] = {obs.pcwr, obs.pcoldwr, obs.irwr, obs.regwr};
        end
        chk("r_seq", {16'd0, st_log[0], st_log[1], st_log[2], st_log[3]}, 32'h0000_012C);
        chk("r_strobes", {16'd0, wr_log[0], wr_log[1], wr_log[2], wr_log[3]}, 32'h0000_E001);
        chk("r_back_fetch", 32'(bus.state_o), 32'd0);

        // Load with three stall cycles in MEM_RD
        opc_cur = OP_LOAD;
        memrd_cycles = 0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 1'b0);
            if (obs_state == 4'd10 && obs.memrd && obs.iord) memrd_cycles++;
        end
        chk("ld_memrd_held", 32'(memrd_cycles), 32'd4);
        cyc(1'b1, 1'b0);
        chk("ld_wb_state", 32'(obs_state), 32'd13);
        chk("ld_wb_ctrl", {30'd0, obs.regwr, obs.wb[0]}, 32'd3);

        // Branch taken then not taken
        opc_cur = OP_BRANCH;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        chk("br_taken", {29'd0, obs_state == 4'd6, obs.pcwr, obs.pcsrc}, 32'd7);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("br_not_taken", {30'd0, obs.pcwr, obs.pcsrc}, 32'd1);
        chk("br_3cyc", 32'(bus.state_o), 32'd0);

        // JAL
        opc_cur = OP_JAL;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("jal_ctrl", {27'd0, obs.regwr, obs.wb, obs.pcwr, obs.pcsrc}, 32'h1B);

        // Illegal opcode parks in TRAP
        opc_cur = 7'b0000000;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'($urandom), 1'($urandom));
        chk("trap_flag", 32'(obs.trap), 32'd1);
        chk("trap_enables", 32'(obs), 32'd1);
        do_reset();

        // Fetch timeout after four waiting cycles
        for (int i = 0; i < TO; i++) cyc(1'b0, 1'b0);
        chk("timeout_trap", 32'(bus.state_o), 32'd14);
        do_reset();

        // mem_ready on the limit cycle completes; then reset abandons a pending store
        opc_cur = OP_STORE;
        for (int i = 0; i < TO; i++) cyc(i == TO - 1, 1'b0);
        chk("limit_rdy_wins", 32'(bus.state_o), 32'd1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        bus.mem_ready = 1'b0;
        #4;
        chk("st_memwr_on", {30'd0, bus.MemWr, bus.state_o == 4'd11}, 32'd3);
        do_reset();

        // Random instruction stream
        trap_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_step == S_TRAP) begin
                trap_cycles++;
                if (trap_cycles > 3) begin
                    trap_cycles = 0;
                    do_reset();
                end
            end
            if (m_step == S_FETCH) begin
                if ($urandom_range(0, 9) == 0) opc_cur = 7'($urandom);
                else opc_cur = legal_ops[$urandom_range(0, 8)];
            end
            cyc($urandom_range(0, 99) < 80, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
